seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. One shared BCD-to-7-segment decoder drives all digits. The block holds a tear-free display frame and steps through the digits one slot at a time. Each step presents one digit's BCD code to the decoder and enables that digit's anode, with a guard gap between digits to suppress ghosting. It sits between the value producers (counters, measurement logic) and the decoder/pad ring.

---
 rtl/seg_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: tear-free frame scan controller for an N-digit 7-seg display.
// In:  clk, rst_n, load, bcd_data, lz_blank_en
// Out: load_ack, frame_start, bcd_sel, dig_en_n, bcd_err
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_data,
  input  logic                    lz_blank_en,
  output logic                    load_ack,
  output logic                    frame_start,
  output logic [3:0]              bcd_sel,
  output logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic                    bcd_err
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  typedef enum logic {
    GUARD,
    ON
  } phase_t;

  phase_t                state;
  phase_t                state_nxt;
  logic [CW-1:0]         slot_cnt;
  logic [IW-1:0]         dig_idx;
  logic [DW-1:0]         disp;
  logic [DW-1:0]         pend;
  logic                  pend_v;

  logic                  slot_end;
  logic                  idx_end;
  logic                  frame_edge;
  logic                  commit;
  logic [DW-1:0]         disp_nxt;
  logic [3:0]            code_nxt;
  logic                  cur_blank;
  logic                  err_nxt;
  logic [NUM_DIGITS-1:0] onehot_n;
  logic [NUM_DIGITS-1:0] en_nxt;

  assign slot_end   = slot_cnt == CW'(SCAN_DIV - 1);
  assign idx_end    = dig_idx == IW'(NUM_DIGITS - 1);
  assign frame_edge = (slot_cnt == '0) && (dig_idx == '0);
  assign commit     = frame_edge && pend_v;

  // bcd_sel is loaded in the commit cycle, so it must see the new frame
  assign disp_nxt = commit ? pend : disp;

  always_comb begin
    logic tail_zero;
    code_nxt  = 4'd0;
    cur_blank = 1'b0;
    onehot_n  = '1;
    tail_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      tail_zero = tail_zero && (disp[4*i +: 4] == 4'd0);
      if (dig_idx == IW'(i)) begin
        code_nxt    = disp_nxt[4*i +: 4];
        onehot_n[i] = 1'b0;
        cur_blank   = (disp[4*i +: 4] > 4'd9) ||
                      ((i != 0) && lz_blank_en && tail_zero);
      end
    end
  end

  always_comb begin
    err_nxt = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (pend[4*i +: 4] > 4'd9) err_nxt = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    en_nxt    = '1;
    if (slot_end) begin
      state_nxt = GUARD;
    end else if (slot_cnt == CW'(GUARD_CYCLES - 1)) begin
      state_nxt = ON;
    end
    if (state == ON && !cur_blank) begin
      en_nxt = onehot_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GUARD;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else begin
      if (slot_end) begin
        slot_cnt <= '0;
        dig_idx  <= idx_end ? '0 : dig_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  // a load in the commit cycle becomes the next pending frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      pend_v <= 1'b0;
    end else if (load) begin
      pend   <= bcd_data;
      pend_v <= 1'b1;
    end else if (commit) begin
      pend_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp    <= '0;
      bcd_err <= 1'b0;
    end else if (commit) begin
      disp    <= pend;
      bcd_err <= err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      bcd_sel     <= 4'd0;
      dig_en_n    <= '1;
    end else begin
      load_ack    <= commit;
      frame_start <= frame_edge;
      dig_en_n    <= en_nxt;
      if (slot_cnt == '0) begin
        bcd_sel <= code_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table, directed and random checks of seg_scan_ctrl
// against a frame-level model (4 digits, 8-cycle slots, 2 guard cycles).
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int GC = 2;
  localparam int FR = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd_data = '0;
  logic        lz_blank_en = 1'b0;
  logic        load_ack;
  logic        frame_start;
  logic [3:0]  bcd_sel;
  logic [3:0]  dig_en_n;
  logic        bcd_err;

  seg_scan_ctrl #(
    .NUM_DIGITS(ND),
    .SCAN_DIV(SD),
    .GUARD_CYCLES(GC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .bcd_data(bcd_data),
    .lz_blank_en(lz_blank_en),
    .load_ack(load_ack),
    .frame_start(frame_start),
    .bcd_sel(bcd_sel),
    .dig_en_n(dig_en_n),
    .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int t;
  int ack_cnt;
  int acks[$];
  logic [15:0] mdisp, mpend;
  logic mpv, merr;

  typedef struct {
    logic [15:0] data;
    logic        lz;
    logic [3:0]  mask;
    logic        err;
  } row_t;
  row_t rows[8];

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %h want %h", nm, t, act, exp);
    end
  endtask

  function automatic logic [3:0] nib(logic [15:0] f, int d);
    return 4'((f >> (4 * d)) & 16'hF);
  endfunction

  function automatic logic blanked(logic [15:0] f, int d, logic lz);
    if (nib(f, d) > 4'd9) return 1'b1;
    if (d == 0) return 1'b0;
    return lz && ((f >> (4 * d)) == 16'd0);
  endfunction

  function automatic logic any_bad(logic [15:0] f);
    for (int d = 0; d < ND; d++) if (nib(f, d) > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // inputs apply to the next clock; t then names that cycle
  task automatic step(input logic ld, input logic [15:0] d, input logic lz);
    logic e_ack;
    int slot, dg;
    logic [3:0] e_en;
    load = ld;
    bcd_data = d;
    lz_blank_en = lz;
    @(posedge clk);
    @(negedge clk);
    t++;
    e_ack = 1'b0;
    if (t % FR == 0 && mpv) begin
      mdisp = mpend;
      mpv = 1'b0;
      merr = any_bad(mdisp);
      e_ack = 1'b1;
    end
    if (ld) begin
      mpend = d;
      mpv = 1'b1;
    end
    slot = t % SD;
    dg = (t / SD) % ND;
    if (slot < GC || blanked(mdisp, dg, lz)) e_en = 4'hF;
    else e_en = ~(4'b0001 << dg);
    chk("load_ack", 16'(load_ack), 16'(e_ack));
    chk("frame_start", 16'(frame_start), 16'(t % FR == 0));
    chk("bcd_sel", 16'(bcd_sel), 16'(nib(mdisp, dg)));
    chk("dig_en_n", 16'(dig_en_n), 16'(e_en));
    chk("bcd_err", 16'(bcd_err), 16'(merr));
    if (load_ack) begin
      ack_cnt++;
      acks.push_back(t);
    end
  endtask

  task automatic idle(int n, logic lz);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, lz);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 16'(load_ack), 16'd0);
    chk("rst_fs", 16'(frame_start), 16'd0);
    chk("rst_sel", 16'(bcd_sel), 16'd0);
    chk("rst_en", 16'(dig_en_n), 16'hF);
    chk("rst_err", 16'(bcd_err), 16'd0);
    rst_n = 1'b1;
    t = -1;
    mdisp = '0;
    mpend = '0;
    mpv = 1'b0;
    merr = 1'b0;
    ack_cnt = 0;
    acks.delete();
  endtask

  initial begin
    logic [3:0] shown;
    logic got;
    int n;
    logic [15:0] rd;
    logic rl;

    rows[0] = '{16'h1234, 1'b0, 4'hF, 1'b0};
    rows[1] = '{16'h0050, 1'b1, 4'h3, 1'b0};
    rows[2] = '{16'h0000, 1'b1, 4'h1, 1'b0};
    rows[3] = '{16'h9A01, 1'b0, 4'hB, 1'b1};
    rows[4] = '{16'h0001, 1'b0, 4'hF, 1'b0};
    rows[5] = '{16'h00A0, 1'b1, 4'h1, 1'b1};
    rows[6] = '{16'hF000, 1'b1, 4'h7, 1'b1};
    rows[7] = '{16'h0300, 1'b1, 4'h7, 1'b0};

    // free-running scan, no load
    do_reset();
    idle(64, 1'b0);
    chk("no_ack", 16'(ack_cnt), 16'd0);

    // single load, committed at the next frame boundary
    do_reset();
    idle(5, 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    idle(60, 1'b0);
    chk("ack_cnt1", 16'(ack_cnt), 16'd1);
    if (ack_cnt > 0) chk("ack_t1", 16'(acks[0]), 16'd32);

    // overwrite before boundary, then load in the commit cycle
    do_reset();
    idle(10, 1'b0);
    step(1'b1, 16'h1111, 1'b0);
    idle(9, 1'b0);
    step(1'b1, 16'h2222, 1'b0);
    idle(11, 1'b0);
    step(1'b1, 16'h3333, 1'b0);
    idle(40, 1'b0);
    chk("ack_cnt2", 16'(ack_cnt), 16'd2);
    if (ack_cnt > 1) begin
      chk("ack_t2a", 16'(acks[0]), 16'd32);
      chk("ack_t2b", 16'(acks[1]), 16'd64);
    end

    // table of frames: digits shown and error flag
    do_reset();
    idle(3, 1'b0);
    foreach (rows[r]) begin
      step(1'b1, rows[r].data, rows[r].lz);
      got = load_ack;
      n = 0;
      while (!got && n < 80) begin
        step(1'b0, 16'h0, rows[r].lz);
        got = load_ack;
        n++;
      end
      chk("tbl_ack", 16'(got), 16'd1);
      while ((t + 1) % FR != 0) step(1'b0, 16'h0, rows[r].lz);
      shown = 4'h0;
      for (int c = 0; c < FR; c++) begin
        step(1'b0, 16'h0, rows[r].lz);
        shown = shown | ~dig_en_n;
      end
      chk("tbl_mask", 16'(shown), 16'(rows[r].mask));
      chk("tbl_err", 16'(bcd_err), 16'(rows[r].err));
    end

    // reset during digit 2 ON phase with a load pending
    do_reset();
    idle(4, 1'b0);
    step(1'b1, 16'h5678, 1'b0);
    idle(30, 1'b0);
    step(1'b1, 16'h4321, 1'b0);
    while (t % FR != 20) step(1'b0, 16'h0, 1'b0);
    chk("pre_rst_en", 16'(dig_en_n), 16'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en", 16'(dig_en_n), 16'hF);
    chk("async_sel", 16'(bcd_sel), 16'd0);
    chk("async_ack", 16'(load_ack), 16'd0);
    chk("async_err", 16'(bcd_err), 16'd0);
    do_reset();
    idle(70, 1'b0);
    chk("rst_no_ack", 16'(ack_cnt), 16'd0);

    // random loads and blanking control against the model
    do_reset();
    rl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) rl = ~rl;
      rd = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rd = rd >> (4 * $urandom_range(1, 4));
      if ($urandom_range(0, 1) == 0) begin
        for (int d = 0; d < ND; d++)
          if (nib(rd, d) > 4'd9) rd = rd & ~(16'h8 << (4 * d));
      end
      step($urandom_range(0, 24) == 0, rd, rl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
